display_capture: RTL
====================

DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4: clk cycles a new anode pattern must hold before its segments are sampled.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock for all state.
REQ-003 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 Port an SHALL be an input, 4 bits wide: digit anodes, active-low; an[0] selects digit 0.
REQ-005 Port seg SHALL be an input, 7 bits wide: segments, active-low; seg[0]=a through seg[6]=g.
REQ-006 Port dp SHALL be an input, 1 bit wide: decimal point, active-low.
REQ-007 Port bcd SHALL be an output, 16 bits wide: last published frame; digit n occupies bcd[4n+3:4n].
REQ-008 Port dp_mask SHALL be an output, 4 bits wide: published decimal points, active-high; bit n belongs to digit n.
REQ-009 Port bcd_valid SHALL be an output, 1 bit wide: one-cycle pulse when bcd and dp_mask update.
REQ-010 Port digit_err SHALL be an output, 4 bits wide: bit n set means the published digit n held a non-decimal pattern.
REQ-011 Port frame_err SHALL be an output, 1 bit wide: one-cycle pulse when a frame is discarded.

Function
REQ-012 All of an, seg and dp SHALL be captured through a 2-flop synchroniser; all later rules apply to the synchronised values.
REQ-013 A settle counter SHALL restart on every change of synchronised an, and a digit SHALL be sampled exactly once, on the cycle the counter reaches SETTLE_CYCLES.
REQ-014 The decimal segment patterns SHALL be: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
REQ-015 A sampled pattern outside the list in REQ-014 SHALL decode to nibble 4'hE and set that digit's pending error bit.
REQ-016 The frame FSM SHALL have states IDLE, COLLECT and PUBLISH; from IDLE it SHALL enter COLLECT on the first settled one-hot-low an.
REQ-017 In COLLECT, each settled one-hot-low an SHALL write that digit's nibble and dp into shadow registers and set seen[n].
REQ-018 When seen==4'b1111, the FSM SHALL go to PUBLISH for one cycle, copy the shadows to the outputs, pulse bcd_valid, clear seen, and return to COLLECT.
REQ-019 A settled an of all-ones (blanking) SHALL be ignored.
REQ-020 A settled an that is neither one-hot-low nor all-ones SHALL pulse frame_err, clear seen and return to IDLE.
REQ-021 A digit re-selected while its seen bit is already set SHALL overwrite the shadow, and no error SHALL be raised.
REQ-022 Latency from the settle-sample of the fourth distinct digit to bcd_valid SHALL be exactly 1 cycle.
REQ-023 Outputs SHALL hold their values between publishes.

Reset
REQ-024 While reset is high, the block SHALL force: bcd=16'h0000, dp_mask=0, digit_err=0, bcd_valid=0, frame_err=0, seen=0, settle counter=0, FSM=IDLE, synchronisers=all-ones.
REQ-025 An assertion of reset mid-frame SHALL discard the partial frame without pulsing frame_err.

Configuration
REQ-026 With DISPLAY_CAPTURE_STABLE_EN defined, a completed frame SHALL be published only if it equals the previous completed frame (bcd, dp_mask and digit_err all compared).
REQ-027 With DISPLAY_CAPTURE_STABLE_EN defined, the first frame after reset SHALL be held as the comparison candidate only, and SHALL NOT be published.
REQ-028 Without DISPLAY_CAPTURE_STABLE_EN, every completed frame SHALL publish.

Structure
REQ-029 The segment pattern constants, the error nibble 4'hE and the FSM state encoding SHALL live in the shared package display_pkg.
REQ-030 Pattern decoding SHALL be done by the combinational sub-module seg7_decode (7-bit pattern in; nibble and error flag out).

Verification
REQ-031 Scan digits 0..3 with patterns 0x79, 0x24, 0x30, 0x19 and SETTLE_CYCLES=4 -> bcd=16'h4321, one bcd_valid pulse, digit_err=0.
REQ-032 Present an=4'b0011 mid-frame -> frame_err pulses once, bcd unchanged, and the next full scan publishes normally.
REQ-033 Hold each an for only 3 cycles (SETTLE_CYCLES=4) -> no sample and no bcd_valid.
REQ-034 Drive digit 2 with pattern 0x7F (blank) -> nibble E at bcd[11:8] and digit_err=4'b0100.
REQ-035 With DISPLAY_CAPTURE_STABLE_EN, scan 16'h1234 then 16'h1235 then 16'h1235 -> exactly one publish, on the third frame, giving 16'h1235.
REQ-036 Assert reset after 2 digits are sampled -> all outputs 0, and the next complete frame publishes fresh data.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for display_capture: segment patterns, error nibble, FSM states.
// Optional feature: DISPLAY_CAPTURE_STABLE_EN (publish only repeated frames).
package display_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [3:0] ERR_NIB = 4'hE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  // Anodes are active-low, so exactly one zero selects exactly one digit.
  function automatic logic onehot_low(input logic [3:0] an);
    return $onehot(~an);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Active-low 7-segment pattern to decimal nibble; unknown patterns flag an error.
import display_pkg::*;

module seg7_decode (
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = ERR_NIB;
    err    = 1'b0;
    unique case (pattern)
      SEG_0:   nibble = 4'd0;
      SEG_1:   nibble = 4'd1;
      SEG_2:   nibble = 4'd2;
      SEG_3:   nibble = 4'd3;
      SEG_4:   nibble = 4'd4;
      SEG_5:   nibble = 4'd5;
      SEG_6:   nibble = 4'd6;
      SEG_7:   nibble = 4'd7;
      SEG_8:   nibble = 4'd8;
      SEG_9:   nibble = 4'd9;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Captures a multiplexed 4-digit 7-segment display into BCD frames.
// Define DISPLAY_CAPTURE_STABLE_EN to publish only frames seen twice in a row.
import display_pkg::*;

module display_capture #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [15:0] bcd,
  output logic [3:0]  dp_mask,
  output logic        bcd_valid,
  output logic [3:0]  digit_err,
  output logic        frame_err
);

  localparam int CW = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CW-1:0] SAT = CW'(SETTLE_CYCLES + 1);

  logic [3:0] an_s1, an_s2, an_q;
  logic [6:0] seg_s1, seg_s2;
  logic       dp_s1, dp_s2;

  logic [CW-1:0] cnt, held;
  logic          sample;

  state_t      state;
  logic [3:0]  seen, seen_nxt;
  logic [15:0] sh_bcd, nb_bcd;
  logic [3:0]  sh_dp, nb_dp;
  logic [3:0]  sh_err, nb_err;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic        nib_err;
  logic        is_onehot, is_blank, pub_ok;

  seg7_decode u_dec (
    .pattern (seg_s2),
    .nibble  (nib),
    .err     (nib_err)
  );

  // held = cycles the current synchronised an has been stable, saturating
  always_comb begin
    if (an_s2 != an_q)
      held = CW'(1);
    else if (cnt == SAT)
      held = cnt;
    else
      held = cnt + CW'(1);
  end

  assign sample    = (held == CW'(SETTLE_CYCLES));
  assign is_onehot = onehot_low(an_s2);
  assign is_blank  = &an_s2;

  always_comb begin
    idx = '0;
    for (int i = 0; i < 4; i++)
      if (!an_s2[i]) idx = 2'(i);
  end

  always_comb begin
    nb_bcd = sh_bcd;
    nb_dp  = sh_dp;
    nb_err = sh_err;
    nb_bcd[{idx, 2'b00} +: 4] = nib;
    nb_dp[idx]  = ~dp_s2;
    nb_err[idx] = nib_err;
    seen_nxt    = seen;
    seen_nxt[idx] = 1'b1;
  end

`ifdef DISPLAY_CAPTURE_STABLE_EN
  logic [15:0] cand_bcd;
  logic [3:0]  cand_dp, cand_err;
  logic        cand_ok;

  assign pub_ok = cand_ok && cand_bcd == nb_bcd &&
                  cand_dp == nb_dp && cand_err == nb_err;
`else
  assign pub_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s1     <= '1;
      an_s2     <= '1;
      an_q      <= '1;
      seg_s1    <= '1;
      seg_s2    <= '1;
      dp_s1     <= 1'b1;
      dp_s2     <= 1'b1;
      cnt       <= '0;
      state     <= IDLE;
      seen      <= '0;
      sh_bcd    <= '0;
      sh_dp     <= '0;
      sh_err    <= '0;
      bcd       <= '0;
      dp_mask   <= '0;
      digit_err <= '0;
      bcd_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef DISPLAY_CAPTURE_STABLE_EN
      cand_bcd  <= '0;
      cand_dp   <= '0;
      cand_err  <= '0;
      cand_ok   <= 1'b0;
`endif
    end else begin
      an_s1     <= an;
      an_s2     <= an_s1;
      an_q      <= an_s2;
      seg_s1    <= seg;
      seg_s2    <= seg_s1;
      dp_s1     <= dp;
      dp_s2     <= dp_s1;
      cnt       <= held;
      bcd_valid <= 1'b0;
      frame_err <= 1'b0;

      if (state == PUBLISH) state <= COLLECT;

      if (sample) begin
        if (is_onehot) begin
          sh_bcd <= nb_bcd;
          sh_dp  <= nb_dp;
          sh_err <= nb_err;
          seen   <= seen_nxt;
          state  <= COLLECT;
          // Publish on the sampling edge so bcd_valid trails it by one cycle
          if (seen_nxt == 4'b1111) begin
            state <= PUBLISH;
            seen  <= '0;
            if (pub_ok) begin
              bcd       <= nb_bcd;
              dp_mask   <= nb_dp;
              digit_err <= nb_err;
              bcd_valid <= 1'b1;
            end
`ifdef DISPLAY_CAPTURE_STABLE_EN
            cand_bcd <= nb_bcd;
            cand_dp  <= nb_dp;
            cand_err <= nb_err;
            cand_ok  <= 1'b1;
`endif
          end
        end else if (!is_blank) begin
          frame_err <= 1'b1;
          seen      <= '0;
          state     <= IDLE;
        end
      end
    end
  end

endmodule
